// File: rtl/data_mem_bridge.sv
// TL-UL device to single-port SRAM bridge with an RdLat tag pipeline and in-order response FIFO.
// Optional build macro DATA_MEM_RANGE_CHK_EN adds word-range and Put-alignment error checks.
package tlul_pkg;
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [7:0]  a_mask;
      logic [63:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_error;
      logic [63:0] d_data;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module data_mem_bridge #(
   parameter int SramAw      = 12,
   parameter int SramDw      = 32,
   parameter int MemDepth    = 4096,
   parameter int Outstanding = 4,
   parameter int RdLat       = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  tlul_pkg::tl_h2d_t     tl_i,
   output tlul_pkg::tl_d2h_t     tl_o,
   output logic                  csb_o,
   output logic                  we_o,
   output logic [SramAw-1:0]     addr_o,
   output logic [SramDw-1:0]     wdata_o,
   output logic [SramDw/8-1:0]   wmask_o,
   input  logic [SramDw-1:0]     rdata_i
);
   localparam int NB   = SramDw / 8;
   localparam int LgNb = $clog2(NB);
   localparam int CntW = $clog2(Outstanding + 1);
   localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;

   typedef struct packed {
      logic       get;
      logic       rd;
      logic       err;
      logic [7:0] src;
      logic [1:0] size;
   } tag_t;

   typedef struct packed {
      logic              get;
      logic              err;
      logic [7:0]        src;
      logic [1:0]        size;
      logic [SramDw-1:0] data;
   } rsp_t;

   logic [31:0]      w_word;
   logic             w_is_get, w_is_put, w_err, w_a_ready, w_accept, w_sel;
   logic             w_push, w_pop, w_dvalid;
   logic [CntW-1:0]  w_pcnt;
   tag_t             w_tag_in;
   rsp_t             w_head;
   logic             w_unused;

   logic [RdLat-1:0] r_vld;
   tag_t             r_tag [RdLat];
   rsp_t             r_fifo [Outstanding];
   logic [PtrW-1:0]  r_wptr, r_rptr;
   logic [CntW-1:0]  r_fcnt;

   assign w_word   = tl_i.a_address >> LgNb;
   assign w_is_get = (tl_i.a_opcode == 3'd4);
   assign w_is_put = (tl_i.a_opcode == 3'd0) || (tl_i.a_opcode == 3'd1);

`ifdef DATA_MEM_RANGE_CHK_EN
   assign w_err = !(w_is_get || w_is_put) || (w_word >= 32'(MemDepth)) ||
                  (w_is_put && ((tl_i.a_address & 32'(NB - 1)) != 32'd0));
`else
   assign w_err = !(w_is_get || w_is_put);
`endif

   // Credit covers everything accepted but not yet popped, so the FIFO can never overflow.
   always_comb begin
      w_pcnt = '0;
      for (int i = 0; i < RdLat; i++) w_pcnt = w_pcnt + CntW'(r_vld[i]);
   end

   assign w_a_ready = ~rst_i & ((w_pcnt + r_fcnt) < CntW'(Outstanding));
   assign w_accept  = tl_i.a_valid & w_a_ready;
   assign w_sel     = w_accept & ~w_err;

   always_comb begin
      csb_o   = 1'b1;
      we_o    = 1'b0;
      addr_o  = '0;
      wdata_o = '0;
      wmask_o = '0;
      if (w_sel) begin
         csb_o  = 1'b0;
         addr_o = w_word[SramAw-1:0];
         we_o   = w_is_put;
         if (w_is_put) wdata_o = tl_i.a_data[SramDw-1:0];
         if (tl_i.a_opcode == 3'd0) wmask_o = '1;
         else if (tl_i.a_opcode == 3'd1) wmask_o = tl_i.a_mask[NB-1:0];
      end
   end

   assign w_tag_in = '{get: w_is_get, rd: w_is_get & ~w_err, err: w_err,
                       src: tl_i.a_source, size: tl_i.a_size};

   always_ff @(posedge clk_i) begin
      if (rst_i) r_vld <= '0;
      else begin
         r_vld[0] <= w_accept;
         for (int i = 1; i < RdLat; i++) r_vld[i] <= r_vld[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < RdLat; i++) r_tag[i] <= r_tag[i-1];
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Outstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // rdata_i lines up with the entry in the last pipeline stage.
   assign w_push   = r_vld[RdLat-1];
   assign w_dvalid = ~rst_i & (r_fcnt != '0);
   assign w_pop    = w_dvalid & tl_i.d_ready;
   assign w_head   = r_fifo[r_rptr];

   always_ff @(posedge clk_i) begin
      if (w_push)
         r_fifo[r_wptr] <= '{get: r_tag[RdLat-1].get, err: r_tag[RdLat-1].err,
                             src: r_tag[RdLat-1].src, size: r_tag[RdLat-1].size,
                             data: r_tag[RdLat-1].rd ? rdata_i : '0};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         r_fcnt <= r_fcnt + CntW'(w_push) - CntW'(w_pop);
      end
   end

   always_comb begin
      tl_o          = '0;
      tl_o.a_ready  = w_a_ready;
      tl_o.d_valid  = w_dvalid;
      tl_o.d_opcode = w_head.get ? 3'd1 : 3'd0;
      tl_o.d_size   = w_head.size;
      tl_o.d_source = w_head.src;
      tl_o.d_error  = w_head.err;
      tl_o.d_data   = 64'(w_head.data);
   end

   assign w_unused = ^{tl_i, w_word};
endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: random traffic on an RdLat=1 instance against a queue/array model,
// plus a directed latency check on an RdLat=2 instance.
module tb_data_mem_bridge;
   import tlul_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tl_h2d_t h0, h1;
   tl_d2h_t d0, d1;
   logic        csb0, we0, csb1, we1;
   logic [11:0] addr0, addr1;
   logic [31:0] wdata0, wdata1, rdata0, rdata1, rd1a;
   logic [3:0]  wmask0, wmask1;

   data_mem_bridge #(.RdLat(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .tl_i(h0), .tl_o(d0), .csb_o(csb0), .we_o(we0),
      .addr_o(addr0), .wdata_o(wdata0), .wmask_o(wmask0), .rdata_i(rdata0));

   data_mem_bridge #(.RdLat(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .tl_i(h1), .tl_o(d1), .csb_o(csb1), .we_o(we1),
      .addr_o(addr1), .wdata_o(wdata1), .wmask_o(wmask1), .rdata_i(rdata1));

   // SRAM environment models
   bit [31:0] mem0 [4096];
   bit [31:0] mem1 [4096];

   always @(posedge clk) begin
      if (!csb0 && we0) begin
         for (int b = 0; b < 4; b++)
            if (wmask0[b]) mem0[addr0][b*8 +: 8] <= wdata0[b*8 +: 8];
      end
      if (!csb0 && !we0) rdata0 <= mem0[addr0];
      if (!csb1 && !we1) rd1a <= mem1[addr1];
      rdata1 <= rd1a;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model for DUT0
   typedef struct {
      bit          get;
      bit          err;
      logic [7:0]  src;
      logic [1:0]  size;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t      q[$];
   bit [31:0] ref_mem [4096];
   int        cnt = 0;
   int        cyc = 0;

   function automatic bit req_err(input logic [2:0] op, input logic [31:0] a);
      bit e;
      e = !(op == 3'd0 || op == 3'd1 || op == 3'd4);
`ifdef DATA_MEM_RANGE_CHK_EN
      if ((a >> 2) >= 32'd4096) e = 1'b1;
      if (op != 3'd4 && a[1:0] != 2'b00) e = 1'b1;
`endif
      return e;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_a_ready", d0.a_ready, 0);
         chk("rst_d_valid", d0.d_valid, 0);
         chk("rst_csb", csb0, 1);
         chk("rst_sram_out", {we0, addr0, wdata0, wmask0}, 0);
         q.delete();
         cnt = 0;
      end else begin
         bit acc, pop;
         chk("a_ready", d0.a_ready, cnt < 4);
         acc = h0.a_valid && d0.a_ready;
         pop = d0.d_valid && h0.d_ready;
         if (acc) begin
            exp_t e;
            int   idx;
            bit   err;
            err = req_err(h0.a_opcode, h0.a_address);
            idx = int'((h0.a_address >> 2) % 4096);
            if (err) begin
               chk("err_csb", csb0, 1);
               chk("err_sram_out", {we0, addr0, wdata0, wmask0}, 0);
            end else begin
               logic [3:0] m;
               m = (h0.a_opcode == 3'd0) ? 4'hF : (h0.a_opcode == 3'd1) ? h0.a_mask[3:0] : 4'h0;
               chk("acc_csb", csb0, 0);
               chk("acc_addr", addr0, idx);
               chk("acc_we", we0, h0.a_opcode != 3'd4);
               chk("acc_wmask", wmask0, m);
               chk("acc_wdata", wdata0, (h0.a_opcode == 3'd4) ? 32'd0 : h0.a_data[31:0]);
               for (int b = 0; b < 4; b++)
                  if (m[b]) ref_mem[idx][b*8 +: 8] = h0.a_data[b*8 +: 8];
            end
            e.get  = (h0.a_opcode == 3'd4);
            e.err  = err;
            e.src  = h0.a_source;
            e.size = h0.a_size;
            e.data = (e.get && !err) ? ref_mem[idx] : 32'd0;
            e.cyc  = cyc;
            q.push_back(e);
         end else begin
            chk("idle_csb", csb0, 1);
            chk("idle_sram_out", {we0, addr0, wdata0, wmask0}, 0);
         end
         if (d0.d_valid) begin
            if (q.size() == 0) chk("spurious_d_valid", d0.d_valid, 0);
            else begin
               chk("d_latency", cyc >= q[0].cyc + 2, 1);
               chk("d_opcode", d0.d_opcode, q[0].get ? 3'd1 : 3'd0);
               chk("d_error", d0.d_error, q[0].err);
               chk("d_source", d0.d_source, q[0].src);
               chk("d_size", d0.d_size, q[0].size);
               chk("d_data", d0.d_data, {32'd0, q[0].data});
               if (pop) void'(q.pop_front());
            end
         end
         cnt = cnt + int'(acc) - int'(pop);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] m);
      bit got;
      got = 1'b0;
      h0.a_valid   = 1'b1;
      h0.a_opcode  = op;
      h0.a_address = a;
      h0.a_data    = {32'd0, d};
      h0.a_mask    = m;
      h0.a_source  = 8'($urandom_range(0, 255));
      h0.a_size    = 2'd2;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = d0.a_ready;
      end
      if (!got) chk("send_timeout", got, 1);
      tick();
      h0.a_valid = 1'b0;
   endtask

   task automatic drain();
      h0.a_valid = 1'b0;
      h0.d_ready = 1'b1;
      for (int i = 0; i < 100 && q.size() != 0; i++) tick();
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      h0 = '0;
      h1 = '0;
      h0.a_valid = 1'b1;
      repeat (3) tick();
      h0.a_valid = 1'b0;
      rst = 1'b0;

      // Write then read back
      h0.d_ready = 1'b1;
      send(3'd0, 32'h10, 32'hDEADBEEF, 8'h0);
      send(3'd4, 32'h10, 32'h0, 8'h0);
      drain();

      // Partial write strobes only in its accept cycle
      h0.a_valid = 1'b1; h0.a_opcode = 3'd1; h0.a_address = 32'h20;
      h0.a_data = 64'h11223344; h0.a_mask = 8'b0101;
      @(negedge clk);
      chk("pp_wmask", wmask0, 4'b0101);
      chk("pp_we_csb", {we0, csb0}, 2'b10);
      tick();
      h0.a_valid = 1'b0;
      @(negedge clk);
      chk("pp_after_csb", csb0, 1);
      send(3'd4, 32'h20, 32'h0, 8'h0);
      drain();

      // Credit exhaustion and release
      h0.d_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(3'd4, 32'(i * 4), 32'h0, 8'h0);
      h0.a_valid = 1'b1; h0.a_opcode = 3'd4; h0.a_address = 32'h10;
      repeat (3) begin
         @(negedge clk);
         chk("full_a_ready", d0.a_ready, 0);
      end
      tick();
      h0.d_ready = 1'b1;
      @(negedge clk);
      chk("pop_cycle_a_ready", d0.a_ready, 0);
      tick();
      h0.d_ready = 1'b0;
      @(negedge clk);
      chk("after_pop_a_ready", d0.a_ready, 1);
      tick();
      h0.a_valid = 1'b0;
      drain();

      // Illegal opcodes and an address past the last word
      send(3'd2, 32'h8, 32'h5, 8'hF);
      send(3'd7, 32'h8, 32'h5, 8'hF);
      send(3'd4, 32'h4000, 32'h0, 8'h0);
      send(3'd0, 32'h13, 32'hCAFEF00D, 8'h0);
      send(3'd4, 32'h10, 32'h0, 8'h0);
      drain();

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         bit acc;
         acc = h0.a_valid && d0.a_ready;
         if (!h0.a_valid || acc) begin
            int r;
            r = int'($urandom_range(0, 9));
            h0.a_valid  = ($urandom_range(0, 3) != 0);
            h0.a_opcode = (r < 4 || r == 9) ? 3'd4 : (r < 6) ? 3'd0 : (r < 8) ? 3'd1 :
                          3'($urandom_range(5, 7));
            h0.a_address = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 32'h7FFF))
                                                        : 32'($urandom_range(0, 63));
            h0.a_data   = {32'd0, 32'($urandom)};
            h0.a_mask   = 8'($urandom_range(0, 15));
            h0.a_source = 8'($urandom_range(0, 255));
            h0.a_size   = 2'($urandom_range(0, 2));
         end
         h0.d_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         tick();
      end
      drain();

      // Reset with three requests in flight
      h0.d_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(3'd4, 32'(i * 4), 32'h0, 8'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_a_ready", d0.a_ready, 1);
      h0.d_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("post_rst_no_d", d0.d_valid, 0);
      end

      // RdLat=2 instance: three back-to-back reads
      mem1[0] = 32'hA0A0_0001;
      mem1[1] = 32'hB0B0_0002;
      mem1[2] = 32'hC0C0_0003;
      tick();
      h1.d_ready = 1'b1;
      h1.a_valid = 1'b1; h1.a_opcode = 3'd4; h1.a_size = 2'd2;
      for (int i = 0; i < 3; i++) begin
         h1.a_address = 32'(i * 4);
         h1.a_source  = 8'(i);
         @(negedge clk);
         chk("rl2_a_ready", d1.a_ready, 1);
         if (i > 0) chk("rl2_no_early_d", d1.d_valid, 0);
         tick();
      end
      h1.a_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rl2_d_valid", d1.d_valid, 1);
         chk("rl2_d_source", d1.d_source, i);
         chk("rl2_d_opcode", d1.d_opcode, 3'd1);
         chk("rl2_d_data", d1.d_data, (i == 0) ? 64'hA0A0_0001 :
                                      (i == 1) ? 64'hB0B0_0002 : 64'hC0C0_0003);
         tick();
      end
      @(negedge clk);
      chk("rl2_done", d1.d_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
